// File: rtl/scan_clk_gen_pkg.sv
// Shared constants and types for the display scan-timing generator.
package scan_clk_pkg;

   // Output mode select: free-running 50% square or single-cycle strobe.
   typedef enum logic {
      MODE_SQUARE = 1'b0,
      MODE_PULSE  = 1'b1
   } scan_mode_e;

   // Terminal count for 480 Hz square output from a 100 MHz board clock.
   localparam int DEFAULT_DIV_480HZ = 104_167;

   // Smallest legal terminal count; an interval is never shorter than 2 cycles.
   localparam int MIN_DIV = 1;

endpackage

// File: rtl/scan_clk_gen_anode_decode.sv
// Phase index to active-low one-hot anode select. Purely combinational;
// the parent registers the result. A phase outside 0..PHASES-1 matches no
// bit, so every anode stays off.
module anode_decode
   import scan_clk_pkg::*;
#(
   parameter int PHASES  = 8,
   parameter int PHASE_W = 3
) (
   input  logic [PHASE_W-1:0] phase_i,
   output logic [PHASES-1:0]  anode_n_o
);

   genvar gi;
   generate
      for (gi = 0; gi < PHASES; gi++) begin : g_anode
         // Drive this anode low only when the phase selects it.
         assign anode_n_o[gi] = (phase_i != PHASE_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/scan_clk_gen.sv
// Scan-timing generator for multiplexed 7-segment displays: runtime-loadable
// divider, square or strobe output, and a phase counter driving registered
// active-low one-hot anode selects.
module scan_clk_gen
   import scan_clk_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int DEFAULT_DIV = DEFAULT_DIV_480HZ,
   parameter int PHASES      = 8,
   parameter int PHASE_W     = 3
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic               enable,
   input  logic               mode,
   input  logic               div_load,
   input  logic [CNT_W-1:0]   div_value,
   output logic               clk_out,
   output logic               tick,
   output logic [PHASE_W-1:0] phase,
   output logic [PHASES-1:0]  anode_n
);

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   div_q, div_d;
   logic               clk_out_q, clk_out_d;
   logic               tick_q, tick_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [PHASES-1:0]  anode_n_q, anode_n_d;
   logic [PHASES-1:0]  anode_dec_n;
   logic               terminal;
   logic               advance;
   scan_mode_e         mode_e;

   assign mode_e = scan_mode_e'(mode);

   // A load always wins over a coincident terminal count.
   assign terminal = enable && !div_load && (cnt_q == div_q);

   // Square mode steps the scan on the rising half of clk_out; strobe mode on every terminal.
   assign advance = terminal && ((mode_e == MODE_PULSE) || !clk_out_q);

   // Next-state for divider, output clock and phase.
   always_comb begin
      cnt_d     = cnt_q;
      div_d     = div_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      phase_d   = phase_q;

      if (div_load) begin
         div_d = (div_value < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_value;
         cnt_d = '0;
      end else if (enable) begin
         if (terminal) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // Strobe mode mirrors tick exactly, so it drops during loads and while disabled.
      if (mode_e == MODE_PULSE) begin
         clk_out_d = terminal;
      end else if (terminal) begin
         clk_out_d = ~clk_out_q;
      end

      if (advance) begin
         phase_d = (phase_q == PHASE_W'(PHASES - 1)) ? '0 : phase_q + PHASE_W'(1);
      end
   end

   anode_decode #(
      .PHASES  (PHASES),
      .PHASE_W (PHASE_W)
   ) u_anode_decode (
      .phase_i   (phase_d),
      .anode_n_o (anode_dec_n)
   );

   // Blank every anode while the scan is disabled.
   always_comb begin
      anode_n_d = '1;
      if (enable) begin
         anode_n_d = anode_dec_n;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         div_q     <= CNT_W'(DEFAULT_DIV);
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         phase_q   <= '0;
         anode_n_q <= '1;
      end else begin
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         phase_q   <= phase_d;
         anode_n_q <= anode_n_d;
      end
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;
   assign phase   = phase_q;
   assign anode_n = anode_n_q;

endmodule

// File: tb/tb_scan_clk_gen.sv
// Self-checking bench for scan_clk_gen: directed vector table, hand-written
// reset sequence, then randomized traffic against an interval/event model.
module tb_scan_clk_gen;

   localparam int CNT_W       = 8;
   localparam int DEFAULT_DIV = 3;
   localparam int PHASES      = 4;
   localparam int PHASE_W     = 2;
   localparam int ALL_OFF     = (1 << PHASES) - 1;

   logic               clk_in = 1'b0;
   logic               reset;
   logic               enable;
   logic               mode;
   logic               div_load;
   logic [CNT_W-1:0]   div_value;
   logic               clk_out;
   logic               tick;
   logic [PHASE_W-1:0] phase;
   logic [PHASES-1:0]  anode_n;

   int n_checks = 0;
   int n_fail   = 0;

   scan_clk_gen #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .PHASES      (PHASES),
      .PHASE_W     (PHASE_W)
   ) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .enable    (enable),
      .mode      (mode),
      .div_load  (div_load),
      .div_value (div_value),
      .clk_out   (clk_out),
      .tick      (tick),
      .phase     (phase),
      .anode_n   (anode_n)
   );

   always #5 clk_in = ~clk_in;

   // ---------------- behavioural reference ----------------
   // The model tracks the position inside the current interval and treats
   // each interval end as an event; the outputs follow from the event stream.
   int m_pos;
   int m_div;
   int m_phase;
   bit m_clk;
   bit m_tick;
   bit m_en;

   function automatic int exp_anode(bit en, int ph);
      return en ? (ALL_OFF - (1 << ph)) : ALL_OFF;
   endfunction

   task automatic model_reset();
      m_pos   = 0;
      m_div   = DEFAULT_DIV;
      m_phase = 0;
      m_clk   = 0;
      m_tick  = 0;
      m_en    = 0;
   endtask

   task automatic model_edge(bit en, bit md, bit ld, int val);
      bit wrap;
      wrap = 0;
      if (ld) begin
         m_div = (val < 1) ? 1 : val;
         m_pos = 0;
      end else if (en) begin
         if (m_pos >= m_div) begin
            wrap  = 1;
            m_pos = 0;
         end else begin
            m_pos = m_pos + 1;
         end
      end
      m_tick = wrap;
      if (md) begin
         m_clk = wrap;
         if (wrap) m_phase = (m_phase + 1) % PHASES;
      end else if (wrap) begin
         m_clk = !m_clk;
         if (m_clk) m_phase = (m_phase + 1) % PHASES;
      end
      m_en = en;
   endtask

   // ---------------- helpers ----------------
   task automatic chk(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(string tag, bit t, bit c, int p, int a);
      chk({tag, ".tick"},    int'(tick),    int'(t));
      chk({tag, ".clk_out"}, int'(clk_out), int'(c));
      chk({tag, ".phase"},   int'(phase),   p);
      chk({tag, ".anode_n"}, int'(anode_n), a);
   endtask

   // Called at a falling edge: drive, let one rising edge pass, return at the next falling edge.
   task automatic step(bit en, bit md, bit ld, int val);
      enable    = en;
      mode      = md;
      div_load  = ld;
      div_value = CNT_W'(val);
      @(posedge clk_in);
      model_edge(en, md, ld, val);
      @(negedge clk_in);
   endtask

   typedef struct {
      bit en;
      bit md;
      bit ld;
      int val;
      int reps;
      bit t;
      bit c;
      int p;
      int an;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // en md ld val reps | tick clk phase anode_n
      // square scan from reset release
      tbl.push_back('{1, 0, 0, 0, 3, 0, 0, 0, 14});
      tbl.push_back('{1, 0, 0, 0, 1, 1, 1, 1, 13});
      tbl.push_back('{1, 0, 0, 0, 3, 0, 1, 1, 13});
      tbl.push_back('{1, 0, 0, 0, 1, 1, 0, 1, 13});
      tbl.push_back('{1, 0, 0, 0, 3, 0, 0, 1, 13});
      tbl.push_back('{1, 0, 0, 0, 1, 1, 1, 2, 11});
      tbl.push_back('{1, 0, 0, 0, 3, 0, 1, 2, 11});
      tbl.push_back('{1, 0, 0, 0, 1, 1, 0, 2, 11});
      tbl.push_back('{1, 0, 0, 0, 3, 0, 0, 2, 11});
      tbl.push_back('{1, 0, 0, 0, 1, 1, 1, 3, 7});
      tbl.push_back('{1, 0, 0, 0, 3, 0, 1, 3, 7});
      tbl.push_back('{1, 0, 0, 0, 1, 1, 0, 3, 7});
      tbl.push_back('{1, 0, 0, 0, 3, 0, 0, 3, 7});
      tbl.push_back('{1, 0, 0, 0, 1, 1, 1, 0, 14});
      // strobe mode: clk_out equals tick, phase steps every interval
      tbl.push_back('{1, 1, 0, 0, 3, 0, 0, 0, 14});
      tbl.push_back('{1, 1, 0, 0, 1, 1, 1, 1, 13});
      tbl.push_back('{1, 1, 0, 0, 3, 0, 0, 1, 13});
      tbl.push_back('{1, 1, 0, 0, 1, 1, 1, 2, 11});
      tbl.push_back('{1, 1, 0, 0, 3, 0, 0, 2, 11});
      tbl.push_back('{1, 1, 0, 0, 1, 1, 1, 3, 7});
      tbl.push_back('{1, 1, 0, 0, 3, 0, 0, 3, 7});
      tbl.push_back('{1, 1, 0, 0, 1, 1, 1, 0, 14});
      // back to square (clk_out continues from 1), load 1 at cnt=2
      tbl.push_back('{1, 0, 0, 0, 2, 0, 1, 0, 14});
      tbl.push_back('{1, 0, 1, 1, 1, 0, 1, 0, 14});
      tbl.push_back('{1, 0, 0, 0, 1, 0, 1, 0, 14});
      tbl.push_back('{1, 0, 0, 0, 1, 1, 0, 0, 14});
      tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 14});
      tbl.push_back('{1, 0, 0, 0, 1, 1, 1, 1, 13});
      // load 0 behaves as load 1
      tbl.push_back('{1, 0, 1, 0, 1, 0, 1, 1, 13});
      tbl.push_back('{1, 0, 0, 0, 1, 0, 1, 1, 13});
      tbl.push_back('{1, 0, 0, 0, 1, 1, 0, 1, 13});
      tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 1, 13});
      tbl.push_back('{1, 0, 0, 0, 1, 1, 1, 2, 11});
      // load of 3 exactly on a terminal edge: no tick, no toggle, no advance
      tbl.push_back('{1, 0, 0, 0, 1, 0, 1, 2, 11});
      tbl.push_back('{1, 0, 1, 3, 1, 0, 1, 2, 11});
      // enable gating at cnt=2, then resume
      tbl.push_back('{1, 0, 0, 0, 2, 0, 1, 2, 11});
      tbl.push_back('{0, 0, 0, 0, 10, 0, 1, 2, 15});
      tbl.push_back('{1, 0, 0, 0, 1, 0, 1, 2, 11});
      tbl.push_back('{1, 0, 0, 0, 1, 1, 0, 2, 11});
      // load 7 and run a little before the mid-scan reset
      tbl.push_back('{1, 0, 1, 7, 1, 0, 0, 2, 11});
      tbl.push_back('{1, 0, 0, 0, 3, 0, 0, 2, 11});
   end

   // ---------------- stimulus ----------------
   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      mode      = 1'b0;
      div_load  = 1'b0;
      div_value = '0;
      model_reset();

      repeat (2) @(negedge clk_in);
      chk_all("reset", 0, 0, 0, ALL_OFF);
      $display("reset: tick=%0d clk_out=%0d phase=%0d anode_n=%b", tick, clk_out, phase, anode_n);
      reset = 1'b0;

      // directed vector table
      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].reps; r++) begin
            step(tbl[i].en, tbl[i].md, tbl[i].ld, tbl[i].val);
            chk_all($sformatf("vec%0d.%0d", i, r), tbl[i].t, tbl[i].c, tbl[i].p, tbl[i].an);
         end
         $display("vec %0d: en=%0d mode=%0d load=%0d val=%0d x%0d -> tick=%0d clk_out=%0d phase=%0d anode_n=%b",
                  i, tbl[i].en, tbl[i].md, tbl[i].ld, tbl[i].val, tbl[i].reps,
                  tick, clk_out, phase, anode_n);
      end

      // asynchronous reset between edges, mid-scan at phase 2
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk_all("async_reset", 0, 0, 0, ALL_OFF);
      $display("async reset: tick=%0d clk_out=%0d phase=%0d anode_n=%b", tick, clk_out, phase, anode_n);
      @(negedge clk_in);
      reset = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         step(1, 0, 0, 0);
         chk_all($sformatf("post_reset.e%0d", e), 0, 0, 0, 14);
      end
      step(1, 0, 0, 0);
      chk_all("post_reset.e4", 1, 1, 1, 13);
      $display("post reset: first tick at edge 4, phase=%0d anode_n=%b", phase, anode_n);

      // randomized traffic against the model
      begin
         bit md_r;
         int fails_before;
         md_r = 0;
         fails_before = n_fail;
         for (int c = 0; c < 2000; c++) begin
            bit en_r;
            bit ld_r;
            int val_r;
            en_r  = ($urandom_range(0, 9) != 0);
            ld_r  = ($urandom_range(0, 24) == 0);
            val_r = $urandom_range(0, 5);
            if ($urandom_range(0, 49) == 0) md_r = !md_r;
            if (c == 1000) begin
               #1;
               reset = 1'b1;
               model_reset();
               @(negedge clk_in);
               reset = 1'b0;
            end
            step(en_r, md_r, ld_r, val_r);
            chk_all($sformatf("rand%0d", c), m_tick, m_clk, m_phase, exp_anode(m_en, m_phase));
         end
         $display("random: 2000 cycles, %0d new failures", n_fail - fails_before);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
